// File: rtl/sdio_crc_seq_pkg.sv
// Shared types and sizes for the SDIO data-line CRC sequencer.
package sdio_crc_seq_pkg;

  localparam int unsigned CRC_LEN = 16;
  localparam int unsigned CNT_W   = 13;
  localparam int unsigned BLK_W   = 10;
  localparam logic [CRC_LEN-1:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CRC,
    STOP,
    CHECK
  } state_e;

endpackage

// File: rtl/sdio_crc_seq_crc16.sv
// One SDIO lane CRC16 (x^16+x^12+x^5+1): serial accumulate, then serial shift-out MSB first.
module sdio_crc16
  import sdio_crc_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               sample,
  input  logic               shift,
  input  logic               din,
  output logic               dout,
  output logic [CRC_LEN-1:0] crc
);

  logic fb;

  assign fb   = din ^ crc[CRC_LEN-1];
  assign dout = crc[CRC_LEN-1];

  // clr wins over sample, sample over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (sample) begin
      crc <= {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end else if (shift) begin
      crc <= {crc[CRC_LEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sdio_crc_seq.sv
// SDIO DAT-line block sequencer: TX appends per-lane CRC16 + stop bit, RX checks it.
// RX direction and the CHECK state exist only with SDIO_CRC_SEQ_RX_CHECK_EN defined.
module sdio_crc_seq
  import sdio_crc_seq_pkg::*;
#(
  parameter int unsigned NLANES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              dir_i,
  input  logic              quad_i,
  input  logic [BLK_W-1:0]  blk_size_i,
  input  logic [NLANES-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic [NLANES-1:0] sd_dat_o,
  output logic              sd_dat_oe_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [NLANES-1:0] crc_err_o
);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           crc_phase_q;
  logic                           rx_q, quad_q;
  logic [BLK_W-1:0]               blk_q;
  logic                           rx_sel;
  logic                           clr, sample, shift;
  logic                           cnt_clr, cnt_inc, phase_set, done_set;
  logic                           beat_end;
  logic [CNT_W-1:0]               data_last;
  logic [NLANES-1:0]              lane_act;
  logic [NLANES-1:0]              dout_w;
  logic [NLANES-1:0][CRC_LEN-1:0] crc_w;

  assign lane_act  = quad_q ? '1 : NLANES'(1);
  // Last data-beat index: 2*(blk+1)-1 nibbles in quad mode, 8*(blk+1)-1 bits otherwise
  assign data_last = quad_q ? CNT_W'({blk_q, 1'b1}) : CNT_W'({blk_q, 3'b111});
  assign beat_end  = crc_phase_q ? (cnt_q == CNT_W'(CRC_LEN - 1)) : (cnt_q == data_last);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    phase_set = 1'b0;
    done_set  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = DATA;
            clr     = 1'b1;
            cnt_clr = 1'b1;
          end
        end
        DATA: begin
          if (data_valid_i) begin
            sample = 1'b1;
            if (!beat_end) begin
              cnt_inc = 1'b1;
            end else if (rx_q && !crc_phase_q) begin
              // RX: the received CRC follows the data on the same lanes
              phase_set = 1'b1;
              cnt_clr   = 1'b1;
            end else if (rx_q) begin
              state_d = CHECK;
            end else begin
              state_d = CRC;
              cnt_clr = 1'b1;
            end
          end
        end
        CRC: begin
          shift = 1'b1;
          if (cnt_q == CNT_W'(CRC_LEN - 1)) state_d = STOP;
          else                              cnt_inc = 1'b1;
        end
        STOP: begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
        CHECK: begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      crc_phase_q <= 1'b0;
      rx_q        <= 1'b0;
      quad_q      <= 1'b0;
      blk_q       <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= done_set;
      if (clr) begin
        rx_q        <= rx_sel;
        quad_q      <= quad_i;
        blk_q       <= blk_size_i;
        crc_phase_q <= 1'b0;
      end else if (phase_set) begin
        crc_phase_q <= 1'b1;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    sdio_crc16 u_crc (
      .clk    (clk_i),
      .rst_n  (~rst_i),
      .clr    (clr),
      .sample (sample & lane_act[k]),
      .shift  (shift & lane_act[k]),
      .din    (data_i[k]),
      .dout   (dout_w[k]),
      .crc    (crc_w[k])
    );
  end

`ifdef SDIO_CRC_SEQ_RX_CHECK_EN
  logic [NLANES-1:0] rem_nz;
  logic [NLANES-1:0] crc_err_q;

  assign rx_sel = dir_i;
  for (genvar k = 0; k < NLANES; k++) begin : g_rem
    assign rem_nz[k] = |crc_w[k];
  end

  // A valid codeword leaves a zero remainder after its own CRC is clocked in
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              crc_err_q <= '0;
    else if (clr)                           crc_err_q <= '0;
    else if (state_q == CHECK && !abort_i)  crc_err_q <= rem_nz & lane_act;
  end
  assign crc_err_o = crc_err_q;
`else
  logic unused_rx;
  assign rx_sel    = 1'b0;
  assign unused_rx = ^{dir_i, crc_w};
  assign crc_err_o = '0;
`endif

  assign data_ready_o = (state_q == DATA);
  assign busy_o       = (state_q != IDLE);
  assign sd_dat_oe_o  = !rx_q && (state_q inside {DATA, CRC, STOP});

  // Inactive lanes idle high; RX never drives
  always_comb begin
    sd_dat_o = '1;
    if (!rx_q) begin
      case (state_q)
        DATA:    sd_dat_o = data_i | ~lane_act;
        CRC:     sd_dat_o = dout_w | ~lane_act;
        default: sd_dat_o = '1;
      endcase
    end
  end

endmodule
